// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, receive FSM states and the source-field
// bundle used by the MII UDP receiver and transmitter.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int unsigned HEADER_BYTES   = 42;

  localparam logic [31:0] CRC32_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TAIL,
    ST_DROP
  } rx_state_e;

  // Sender identity carried alongside each payload
  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } src_info_t;

endpackage

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble, LSB first.
// Ports: crc_i current register, nib_i nibble, crc_o_c next register.
module crc32_nibble
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] crc_o_c
);

  logic [31:0] crc;

  always_comb begin
    crc = crc_i;
    for (int i = 0; i < 4; i++) begin
      if (crc[0] ^ nib_i[i]) crc = (crc >> 1) ^ CRC32_POLY;
      else                   crc = crc >> 1;
    end
    crc_o_c = crc;
  end

endmodule

// File: rtl/ethernet_udp_receive.sv
// MII receiver: deserialises nibbles, validates preamble/SFD, Ethernet, IPv4
// and UDP headers plus FCS, and presents one fixed-size UDP payload per
// accepted frame.
// Ports: clk/rstn (PHY rx clock, async active-low reset), rx_dv/rx_er/rx_d
// (MII rx), data/src_mac/src_ip/src_port (last accepted datagram),
// valid/drop (one-cycle accept/reject pulses).
module ethernet_udp_receive
  import eth_pkg::*;
#(
  parameter int unsigned DATA_BYTES      = 16,
  parameter logic [47:0] LOCAL_MAC       = 48'h1a_2b_3c_4d_5e_6f,
  parameter logic [31:0] LOCAL_IP        = 32'h11_22_33_44,
  parameter logic [15:0] LOCAL_PORT      = 16'h1000,
  parameter bit          USE_IP_CHECKSUM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rx_dv,
  input  logic                    rx_er,
  input  logic [3:0]              rx_d,
  output logic [8*DATA_BYTES-1:0] data,
  output logic                    valid,
  output logic [47:0]             src_mac,
  output logic [31:0]             src_ip,
  output logic [15:0]             src_port,
  output logic                    drop
);

  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LAST_HDR  = CNT_W'(HEADER_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_PAY  = CNT_W'(HEADER_BYTES + DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] MIN_BYTES = CNT_W'(46 + DATA_BYTES);
  localparam logic [15:0]      UDP_LEN   = 16'(8 + DATA_BYTES);
  localparam logic [15:0]      IP_LEN    = 16'(28 + DATA_BYTES);

  // Reset release synchroniser; assertion stays asynchronous
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= '0;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  rx_state_e        state_q, state_d;
  logic             phase_q, phase_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [15:0]      csum_q, csum_d;
  logic [39:0]      win_q, win_d;
  logic             in_frame_q, in_frame_d;
  src_info_t        src_stg_q, src_stg_d, src_out_q, src_out_d;
  logic [DW-1:0]    pay_stg_q, pay_stg_d, data_q, data_d;
  logic             valid_q, valid_d, drop_q, drop_d;

  logic [7:0]  byte_c;
  logic [47:0] win_nx_c;
  logic [31:0] crc_nx_c;
  logic [16:0] csum_sum_c;
  logic [15:0] csum_fold_c;
  logic        hdr_bad_c;
  logic        frame_ok_c;

  crc32_nibble u_crc (
    .crc_i   (crc_q),
    .nib_i   (rx_d),
    .crc_o_c (crc_nx_c)
  );

  assign byte_c      = {rx_d, lo_nib_q};
  assign win_nx_c    = {win_q, byte_c};
  // Ones'-complement add of the word completing now, end-around carry folded
  assign csum_sum_c  = 17'(csum_q) + 17'({win_q[7:0], byte_c});
  assign csum_fold_c = csum_sum_c[15:0] + 16'(csum_sum_c[16]);
  assign frame_ok_c  = (crc_q == CRC32_RESIDUE)
                    && (!USE_IP_CHECKSUM || (csum_q == 16'hFFFF))
                    && !phase_q
                    && (byte_cnt_q >= MIN_BYTES);

  // Header field check at the byte where each field completes
  always_comb begin
    hdr_bad_c = 1'b0;
    case (byte_cnt_q)
      CNT_W'(5):  hdr_bad_c = !((win_nx_c == LOCAL_MAC) || (win_nx_c == '1));
      CNT_W'(13): hdr_bad_c = win_nx_c[15:0] != ETHERTYPE_IPV4;
      CNT_W'(14): hdr_bad_c = win_nx_c[7:0] != IP_VER_IHL;
      CNT_W'(17): hdr_bad_c = win_nx_c[15:0] != IP_LEN;
      CNT_W'(21): hdr_bad_c = !((win_nx_c[15:0] == 16'h0000) || (win_nx_c[15:0] == 16'h4000));
      CNT_W'(23): hdr_bad_c = win_nx_c[7:0] != IP_PROTO_UDP;
      CNT_W'(33): hdr_bad_c = win_nx_c[31:0] != LOCAL_IP;
      CNT_W'(37): hdr_bad_c = win_nx_c[15:0] != LOCAL_PORT;
      CNT_W'(39): hdr_bad_c = win_nx_c[15:0] != UDP_LEN;
      default:    hdr_bad_c = 1'b0;
    endcase
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lo_nib_d   = lo_nib_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    csum_d     = csum_q;
    win_d      = win_q;
    in_frame_d = in_frame_q;
    src_stg_d  = src_stg_q;
    pay_stg_d  = pay_stg_q;
    src_out_d  = src_out_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    drop_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_dv && (rx_d == 4'h5)) begin
          state_d    = ST_PREAMBLE;
          in_frame_d = 1'b1;
        end
      end

      ST_PREAMBLE: begin
        if (!rx_dv) begin
          drop_d     = 1'b1;
          in_frame_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (rx_er) begin
          state_d = ST_DROP;
        end else if (rx_d == 4'hD) begin
          state_d    = ST_HEADER;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          crc_d      = CRC32_INIT;
          csum_d     = '0;
        end else if (rx_d != 4'h5) begin
          state_d = ST_DROP;
        end
      end

      ST_HEADER, ST_PAYLOAD, ST_TAIL: begin
        if (!rx_dv) begin
          // Only a frame that reached TAIL can be accepted
          in_frame_d = 1'b0;
          state_d    = ST_IDLE;
          if ((state_q == ST_TAIL) && frame_ok_c) begin
            valid_d   = 1'b1;
            src_out_d = src_stg_q;
            data_d    = pay_stg_q;
          end else begin
            drop_d = 1'b1;
          end
        end else if (rx_er) begin
          state_d = ST_DROP;
        end else begin
          crc_d   = crc_nx_c;
          phase_d = !phase_q;
          if (!phase_q) begin
            lo_nib_d = rx_d;
          end else begin
            byte_cnt_d = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
            if (state_q == ST_HEADER) begin
              win_d = win_nx_c[39:0];
              if (byte_cnt_q == CNT_W'(11)) src_stg_d.mac  = win_nx_c;
              if (byte_cnt_q == CNT_W'(29)) src_stg_d.ip   = win_nx_c[31:0];
              if (byte_cnt_q == CNT_W'(35)) src_stg_d.port = win_nx_c[15:0];
              // IPv4 header words end on odd bytes 15..33
              if (byte_cnt_q[0] && (byte_cnt_q >= CNT_W'(15)) && (byte_cnt_q <= CNT_W'(33)))
                csum_d = csum_fold_c;
              if (hdr_bad_c)                    state_d = ST_DROP;
              else if (byte_cnt_q == LAST_HDR)  state_d = ST_PAYLOAD;
            end else if (state_q == ST_PAYLOAD) begin
              pay_stg_d = {byte_c, pay_stg_q[DW-1:8]};
              if (byte_cnt_q == LAST_PAY) state_d = ST_TAIL;
            end
          end
        end
      end

      ST_DROP: begin
        if (!rx_dv) begin
          drop_d     = in_frame_q;
          in_frame_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_DROP;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DROP;
      phase_q    <= 1'b0;
      lo_nib_q   <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC32_INIT;
      csum_q     <= '0;
      win_q      <= '0;
      in_frame_q <= 1'b0;
      src_stg_q  <= '0;
      pay_stg_q  <= '0;
      src_out_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lo_nib_q   <= lo_nib_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      csum_q     <= csum_d;
      win_q      <= win_d;
      in_frame_q <= in_frame_d;
      src_stg_q  <= src_stg_d;
      pay_stg_q  <= pay_stg_d;
      src_out_q  <= src_out_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign drop     = drop_q;
  assign src_mac  = src_out_q.mac;
  assign src_ip   = src_out_q.ip;
  assign src_port = src_out_q.port;

endmodule

// File: tb/tb_ethernet_udp_receive.sv
// Self-checking bench for ethernet_udp_receive: builds frames with a
// byte-wise CRC-32 and IPv4 checksum model, drives them as MII nibbles and
// compares each valid/drop pulse against a scoreboard of expected outcomes.
module tb_ethernet_udp_receive;

  localparam int unsigned DATA_BYTES = 16;
  localparam int unsigned DW         = 8 * DATA_BYTES;
  localparam logic [47:0] LOCAL_MAC  = 48'h1a_2b_3c_4d_5e_6f;
  localparam logic [47:0] BCAST_MAC  = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] OTHER_MAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] LOCAL_IP   = 32'h11_22_33_44;
  localparam logic [15:0] LOCAL_PORT = 16'h1000;
  localparam logic [47:0] SRC_MAC    = 48'haa_bb_cc_dd_ee_ff;
  localparam logic [31:0] SRC_IP     = 32'h55_66_77_88;
  localparam logic [15:0] SRC_PORT   = 16'h1000;

  logic          clk, rstn, rx_dv, rx_er;
  logic [3:0]    rx_d;
  logic [DW-1:0] data;
  logic          valid, drop;
  logic [47:0]   src_mac;
  logic [31:0]   src_ip;
  logic [15:0]   src_port;

  ethernet_udp_receive dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .rx_d     (rx_d),
    .data     (data),
    .valid    (valid),
    .src_mac  (src_mac),
    .src_ip   (src_ip),
    .src_port (src_port),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    bit            is_valid;
    logic [DW-1:0] data;
    logic [47:0]   mac;
    logic [31:0]   ip;
    logic [15:0]   port;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [7:0]    frm[$];
  logic [DW-1:0] h_data;
  logic [47:0]   h_mac;
  logic [31:0]   h_ip;
  logic [15:0]   h_port;
  logic          prev_dv;
  int            total, bad;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pay_of(input logic [7:0] base);
    logic [DW-1:0] p;
    for (int i = 0; i < DATA_BYTES; i++) p[8*i +: 8] = base + 8'(i);
    return p;
  endfunction

  // Expected outputs at the pulse: new datagram on accept, held values on reject
  task automatic expect_pulse(input bit ok, input logic [DW-1:0] pay);
    exp_t e;
    if (ok) begin
      h_data = pay;
      h_mac  = SRC_MAC;
      h_ip   = SRC_IP;
      h_port = SRC_PORT;
    end
    e.is_valid = ok;
    e.data     = h_data;
    e.mac      = h_mac;
    e.ip       = h_ip;
    e.port     = h_port;
    sb.push_back(e);
  endtask

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] dport,
                             input logic [7:0] pbase, input bit flip);
    logic [7:0]  ip_hdr[20];
    logic [31:0] s;
    logic [15:0] ck;
    logic [31:0] crc;
    logic [15:0] ip_len, udp_len;
    ip_len  = 16'(28 + DATA_BYTES);
    udp_len = 16'(8 + DATA_BYTES);
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(SRC_MAC[8*i +: 8]);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    ip_hdr[0]  = 8'h45;         ip_hdr[1]  = 8'h00;
    ip_hdr[2]  = ip_len[15:8];  ip_hdr[3]  = ip_len[7:0];
    ip_hdr[4]  = 8'h12;         ip_hdr[5]  = 8'h34;
    ip_hdr[6]  = 8'h40;         ip_hdr[7]  = 8'h00;
    ip_hdr[8]  = 8'h40;         ip_hdr[9]  = 8'h11;
    ip_hdr[10] = 8'h00;         ip_hdr[11] = 8'h00;
    for (int i = 0; i < 4; i++) ip_hdr[12+i] = SRC_IP[8*(3-i) +: 8];
    for (int i = 0; i < 4; i++) ip_hdr[16+i] = LOCAL_IP[8*(3-i) +: 8];
    s = 32'h0;
    for (int w = 0; w < 10; w++) s = s + {16'h0, ip_hdr[2*w], ip_hdr[2*w+1]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    ck = ~s[15:0];
    ip_hdr[10] = ck[15:8];
    ip_hdr[11] = ck[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(ip_hdr[i]);
    frm.push_back(SRC_PORT[15:8]);
    frm.push_back(SRC_PORT[7:0]);
    frm.push_back(dport[15:8]);
    frm.push_back(dport[7:0]);
    frm.push_back(udp_len[15:8]);
    frm.push_back(udp_len[7:0]);
    frm.push_back(8'h00);
    frm.push_back(8'h00);
    for (int i = 0; i < DATA_BYTES; i++) frm.push_back(pbase + 8'(i));
    frm.push_back(8'h00);
    frm.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      crc = crc ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
    if (flip) frm[42+3] = frm[42+3] ^ 8'h10;
  endtask

  // Drive preamble/SFD then frm as nibbles; optional rx_er, early stop and reset pulse
  task automatic send_frame(input int er_nib, input int stop_nib, input int rst_nib, input int ifg);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rx_dv = 1'b1;
      rx_er = 1'b0;
      rx_d  = 4'h5;
    end
    @(negedge clk);
    rx_d = 4'hD;
    for (int i = 0; i < 2 * frm.size(); i++) begin
      if (i == stop_nib) break;
      @(negedge clk);
      rx_d  = i[0] ? frm[i/2][7:4] : frm[i/2][3:0];
      rx_er = (i == er_nib);
      if (i == rst_nib) rstn = 1'b0;
      if ((rst_nib >= 0) && (i == rst_nib + 6)) rstn = 1'b1;
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_d  = 4'h0;
    repeat (ifg - 1) @(negedge clk);
  endtask

  // Pulse monitor
  always @(posedge clk) begin
    #1;
    if (valid || drop) begin
      check("valid_drop_excl", DW'(valid & drop), '0);
      check("latency_from_dv_fall", DW'({prev_dv, rx_dv}), DW'(2'b10));
      if (sb.size() == 0) begin
        check("spurious_pulse", DW'({valid, drop}), '0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_valid", DW'(valid), DW'(mon_e.is_valid));
        check("pulse_kind_drop", DW'(drop), DW'(!mon_e.is_valid));
        check("data", data, mon_e.data);
        check("src_mac", DW'(src_mac), DW'(mon_e.mac));
        check("src_ip", DW'(src_ip), DW'(mon_e.ip));
        check("src_port", DW'(src_port), DW'(mon_e.port));
      end
    end
    prev_dv = rx_dv;
  end

  initial begin
    total   = 0;
    bad     = 0;
    rstn    = 1'b0;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rx_d    = 4'h0;
    prev_dv = 1'b0;
    h_data  = '0;
    h_mac   = '0;
    h_ip    = '0;
    h_port  = '0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", DW'(valid), '0);
    check("rst_drop", DW'(drop), '0);
    check("rst_data", data, '0);
    check("rst_src_mac", DW'(src_mac), '0);
    check("rst_src_ip", DW'(src_ip), '0);
    check("rst_src_port", DW'(src_port), '0);

    // Good unicast frame
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h00, 1'b0);
    expect_pulse(1'b1, pay_of(8'h00));
    send_frame(-1, -1, -1, 12);

    // Corrupted payload nibble: FCS fails
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h00, 1'b1);
    expect_pulse(1'b0, '0);
    send_frame(-1, -1, -1, 12);

    // Wrong destination port, then wrong destination MAC
    build_frame(LOCAL_MAC, 16'h1001, 8'h00, 1'b0);
    expect_pulse(1'b0, '0);
    send_frame(-1, -1, -1, 12);
    build_frame(OTHER_MAC, LOCAL_PORT, 8'h00, 1'b0);
    expect_pulse(1'b0, '0);
    send_frame(-1, -1, -1, 12);

    // Broadcast destination accepted
    build_frame(BCAST_MAC, LOCAL_PORT, 8'h20, 1'b0);
    expect_pulse(1'b1, pay_of(8'h20));
    send_frame(-1, -1, -1, 12);

    // rx_er at header byte 20, then rx_dv lost mid-payload; 12-byte IFG each
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h00, 1'b0);
    expect_pulse(1'b0, '0);
    send_frame(40, -1, -1, 24);
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h00, 1'b0);
    expect_pulse(1'b0, '0);
    send_frame(-1, 94, -1, 24);

    // Back-to-back with 1-cycle IFG
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h00, 1'b0);
    expect_pulse(1'b1, pay_of(8'h00));
    send_frame(-1, -1, -1, 1);
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'hF0, 1'b0);
    expect_pulse(1'b1, pay_of(8'hF0));
    send_frame(-1, -1, -1, 12);

    // Reset at payload byte 5, released while rx_dv still high: no pulse
    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h40, 1'b0);
    h_data = '0;
    h_mac  = '0;
    h_ip   = '0;
    h_port = '0;
    send_frame(-1, -1, 94, 12);
    check("midrst_data", data, h_data);
    check("midrst_src_mac", DW'(src_mac), DW'(h_mac));
    check("midrst_src_ip", DW'(src_ip), DW'(h_ip));
    check("midrst_src_port", DW'(src_port), DW'(h_port));

    build_frame(LOCAL_MAC, LOCAL_PORT, 8'h60, 1'b0);
    expect_pulse(1'b1, pay_of(8'h60));
    send_frame(-1, -1, -1, 12);

    repeat (20) @(negedge clk);
    check("pulses_outstanding", DW'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
